fifo_write_arbiter: RTL and testbench

Shares the single write port of the buffer between two independent requesters (A, B) using round-robin arbitration. Owns all pointer and occupancy state: write pointer, read pointer, occupancy count, full and empty flags. Drives the storage array's write enable, address and data. Sits between the two producer blocks and the buffer memory; the consumer drives read_Enable directly.

---
 rtl/fifo_write_arbiter_if.sv | 36 +++
 rtl/fifo_write_arbiter.sv | 84 ++++++++
 tb/tb_fifo_write_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between two producers, the consumer read strobe and the buffer arbiter.
// Latency: none, plain wires. The slave (arbiter) drives grants, storage write signals and state.
// Backpressure: a producer whose grant is low must hold its req/data; nothing is queued.
interface fifo_write_arbiter_if #(
  parameter int BUFFER_WIDTH = 3,
  parameter int DATA_WIDTH   = 8
);
  logic                    req_A;
  logic [DATA_WIDTH-1:0]   data_A;
  logic                    req_B;
  logic [DATA_WIDTH-1:0]   data_B;
  logic                    read_Enable;
  logic                    grant_A;
  logic                    grant_B;
  logic                    mem_Write_Enable;
  logic [DATA_WIDTH-1:0]   mem_Write_Data;
  logic [BUFFER_WIDTH-1:0] write_Pointer;
  logic [BUFFER_WIDTH-1:0] read_Pointer;
  logic                    sig_Full;
  logic                    sig_Empty;
  logic [BUFFER_WIDTH:0]   occupancy;

  // Producer/consumer side
  modport master (
    output req_A, data_A, req_B, data_B, read_Enable,
    input  grant_A, grant_B, mem_Write_Enable, mem_Write_Data,
           write_Pointer, read_Pointer, sig_Full, sig_Empty, occupancy
  );

  // Arbiter side
  modport slave (
    input  req_A, data_A, req_B, data_B, read_Enable,
    output grant_A, grant_B, mem_Write_Enable, mem_Write_Data,
           write_Pointer, read_Pointer, sig_Full, sig_Empty, occupancy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one buffer write port between requesters A and B; owns pointers/occupancy.
// Latency: grants and storage write strobe are combinational; pointers/occupancy/flags update on the edge.
// Backpressure: no grant while full; a denied requester holds req/data. Ports: clock, reset (async low), bus (slave).
module fifo_write_arbiter #(
  parameter int BUFFER_WIDTH = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic          clock,
  input  logic          reset,
  fifo_write_arbiter_if.slave bus
);

  localparam logic [BUFFER_WIDTH:0] DEPTH = {1'b1, {BUFFER_WIDTH{1'b0}}};

  typedef enum logic {PRIO_A, PRIO_B} prio_t;

  prio_t                   prio_q, prio_d;
  logic [BUFFER_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUFFER_WIDTH:0]   occ_q;
  logic                    full, empty;
  logic                    grant_a, grant_b;
  logic                    wr_acc, rd_acc;

  // Flags come straight from the registered count, so a write is refused
  // on the cycle a read frees the last slot.
  assign full   = (occ_q == DEPTH);
  assign empty  = (occ_q == '0);
  assign wr_acc = grant_a | grant_b;
  assign rd_acc = bus.read_Enable & ~empty;

  // Priority register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prio_q <= PRIO_A;
    else        prio_q <= prio_d;
  end

  // Grant decode and priority next-state. Reset gates the grants so nothing
  // looks accepted while the state is being cleared.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    prio_d  = prio_q;
    if (reset && !full) begin
      if (bus.req_A && bus.req_B) begin
        if (prio_q == PRIO_A) grant_a = 1'b1;
        else                  grant_b = 1'b1;
      end else begin
        grant_a = bus.req_A;
        grant_b = bus.req_B;
      end
    end
    if (grant_a)      prio_d = PRIO_B;
    else if (grant_b) prio_d = PRIO_A;
  end

  // Pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign bus.grant_A          = grant_a;
  assign bus.grant_B          = grant_b;
  assign bus.mem_Write_Enable = wr_acc;
  assign bus.mem_Write_Data   = grant_a ? bus.data_A :
                                grant_b ? bus.data_B : '0;
  assign bus.write_Pointer    = wr_ptr_q;
  assign bus.read_Pointer     = rd_ptr_q;
  assign bus.sig_Full         = full;
  assign bus.sig_Empty        = empty;
  assign bus.occupancy        = occ_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: queue-level model checked every negedge plus directed literal checks.
// Latency: stimulus is applied 1 time unit after each rising edge and held for the whole cycle.
// Backpressure: requesters hold req/data while denied, as a real producer would.
module tb_fifo_write_arbiter;
  localparam int BW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fifo_write_arbiter_if #(.BUFFER_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(.BUFFER_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
  endtask

  // Behavioural model: integer counters, modulo arithmetic, a "whose turn" bit
  int m_wp     = 0;
  int m_rp     = 0;
  int m_occ    = 0;
  bit m_turn_a = 1'b1;

  bit e_ga, e_gb;
  int e_dat, e_wr, e_rd;

  always_comb begin
    e_ga = 1'b0;
    e_gb = 1'b0;
    if (reset && m_occ < DEPTH) begin
      if (bus.req_A && bus.req_B) begin
        e_ga = m_turn_a;
        e_gb = !m_turn_a;
      end else begin
        e_ga = bus.req_A;
        e_gb = bus.req_B;
      end
    end
    e_dat = e_ga ? int'(bus.data_A) : (e_gb ? int'(bus.data_B) : 0);
    e_wr  = (e_ga || e_gb) ? 1 : 0;
    e_rd  = (bus.read_Enable && m_occ > 0) ? 1 : 0;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_wp     <= 0;
      m_rp     <= 0;
      m_occ    <= 0;
      m_turn_a <= 1'b1;
    end else begin
      m_wp  <= (m_wp + e_wr) % DEPTH;
      m_rp  <= (m_rp + e_rd) % DEPTH;
      m_occ <= m_occ + e_wr - e_rd;
      if (e_ga)      m_turn_a <= 1'b0;
      else if (e_gb) m_turn_a <= 1'b1;
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_grant_A",   int'(bus.grant_A),          int'(e_ga));
      chk("cyc_grant_B",   int'(bus.grant_B),          int'(e_gb));
      chk("cyc_mem_we",    int'(bus.mem_Write_Enable), e_wr);
      chk("cyc_mem_data",  int'(bus.mem_Write_Data),   e_dat);
      chk("cyc_wr_ptr",    int'(bus.write_Pointer),    m_wp);
      chk("cyc_rd_ptr",    int'(bus.read_Pointer),     m_rp);
      chk("cyc_occupancy", int'(bus.occupancy),        m_occ);
      chk("cyc_full",      int'(bus.sig_Full),         (m_occ == DEPTH) ? 1 : 0);
      chk("cyc_empty",     int'(bus.sig_Empty),        (m_occ == 0) ? 1 : 0);
    end
  end

  // Values seen mid-cycle by the last step()
  int g_a, g_b, g_dat;

  task automatic drive(input bit ra, input logic [DW-1:0] da,
                       input bit rb, input logic [DW-1:0] db, input bit re);
    bus.req_A       = ra;
    bus.data_A      = da;
    bus.req_B       = rb;
    bus.data_B      = db;
    bus.read_Enable = re;
  endtask

  task automatic step(input bit ra, input logic [DW-1:0] da,
                      input bit rb, input logic [DW-1:0] db, input bit re);
    drive(ra, da, rb, db, re);
    @(negedge clock);
    g_a   = int'(bus.grant_A);
    g_b   = int'(bus.grant_B);
    g_dat = int'(bus.mem_Write_Data);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wr_ptr", int'(bus.write_Pointer), 0);
    chk("rst_occ",    int'(bus.occupancy),     0);
    chk("rst_empty",  int'(bus.sig_Empty),     1);
    chk("rst_full",   int'(bus.sig_Full),      0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Alternation: A,B,A,B,A,B
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b0);
      chk("alt_grant_A", g_a,   (i % 2 == 0) ? 1 : 0);
      chk("alt_grant_B", g_b,   (i % 2 == 0) ? 0 : 1);
      chk("alt_data",    g_dat, (i % 2 == 0) ? 'hA0 + i : 'hB0 + i);
    end
    chk("alt_wr_ptr", int'(bus.write_Pointer), 6);
    chk("alt_occ",    int'(bus.occupancy),     6);

    // One read brings occupancy to 5
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("rd_occ",    int'(bus.occupancy),    5);
    chk("rd_rd_ptr", int'(bus.read_Pointer), 1);

    // Asynchronous reset mid-operation with both requesters active
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    reset = 1'b0;
    #1;
    chk("mrst_wr_ptr",  int'(bus.write_Pointer), 0);
    chk("mrst_rd_ptr",  int'(bus.read_Pointer),  0);
    chk("mrst_occ",     int'(bus.occupancy),     0);
    chk("mrst_empty",   int'(bus.sig_Empty),     1);
    chk("mrst_full",    int'(bus.sig_Full),      0);
    chk("mrst_grant_A", int'(bus.grant_A),       0);
    chk("mrst_grant_B", int'(bus.grant_B),       0);
    @(negedge clock);
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    step(1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
    chk("post_rst_grant_A", g_a,   1);
    chk("post_rst_grant_B", g_b,   0);
    chk("post_rst_data",    g_dat, 'h33);

    // Fill from empty with A only; pointer wraps to 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h40 + 8'(i), 1'b0, '0, 1'b0);
      chk("fill_grant_A", g_a, 1);
    end
    chk("fill_occ",    int'(bus.occupancy),     8);
    chk("fill_full",   int'(bus.sig_Full),      1);
    chk("fill_empty",  int'(bus.sig_Empty),     0);
    chk("fill_wr_ptr", int'(bus.write_Pointer), 0);
    step(1'b1, 8'h48, 1'b0, '0, 1'b0);
    chk("full_grant_A",  g_a,   0);
    chk("full_data",     g_dat, 0);
    chk("full_occ",      int'(bus.occupancy),     8);
    chk("full_wr_ptr",   int'(bus.write_Pointer), 0);

    // Full plus read: write blocked this cycle, granted the next
    step(1'b0, '0, 1'b1, 8'hC1, 1'b1);
    chk("fr_grant_B", g_b, 0);
    chk("fr_rd_ptr",  int'(bus.read_Pointer), 1);
    chk("fr_occ",     int'(bus.occupancy),    7);
    chk("fr_full",    int'(bus.sig_Full),     0);
    step(1'b0, '0, 1'b1, 8'hC1, 1'b0);
    chk("fr2_grant_B", g_b,   1);
    chk("fr2_data",    g_dat, 'hC1);
    chk("fr2_occ",     int'(bus.occupancy),     8);
    chk("fr2_wr_ptr",  int'(bus.write_Pointer), 1);

    // Empty plus read: write goes through, read ignored
    do_reset();
    step(1'b1, 8'h55, 1'b0, '0, 1'b1);
    chk("er_grant_A", g_a, 1);
    chk("er_occ",     int'(bus.occupancy),    1);
    chk("er_rd_ptr",  int'(bus.read_Pointer), 0);

    // Steady stream at occupancy 3
    step(1'b1, 8'h56, 1'b0, '0, 1'b0);
    step(1'b1, 8'h57, 1'b0, '0, 1'b0);
    chk("ss_start_occ", int'(bus.occupancy), 3);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b1, 8'h60 + 8'(i), 1'b1);
      chk("ss_grant_B", g_b, 1);
    end
    chk("ss_occ",    int'(bus.occupancy),     3);
    chk("ss_wr_ptr", int'(bus.write_Pointer), 7);
    chk("ss_rd_ptr", int'(bus.read_Pointer),  4);

    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
